board_renderer: RTL and testbench

BOARD_RENDERER -- requirements
Module: board_renderer

---
 rtl/board_pkg.sv | 24 ++
 rtl/board_renderer_if.sv | 17 +
 rtl/tile_color_lut.sv | 20 ++
 rtl/board_renderer.sv | 141 ++++++++++++++
 tb/tb_board_renderer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared constants and types for the 4x4 tile board renderer: board size,
// exponent width, border thickness and the tile colour table.
package board_pkg;

  localparam int BOARD_CELLS = 16;
  localparam int EXP_W       = 4;
  localparam int BORDER_PX   = 2;

  typedef logic [EXP_W-1:0]             exp_t;
  typedef logic [2:0]                   color_t;
  typedef exp_t [BOARD_CELLS-1:0]       board_t;

  localparam color_t COL_BG     = 3'b000;
  localparam color_t COL_BORDER = 3'b111;
  localparam color_t COL_BLINK  = 3'b111;
  localparam exp_t   EXP_BLINK  = 4'd11;

  // Entry n is the steady colour of a tile with exponent n (index 15 first).
  localparam logic [BOARD_CELLS-1:0][2:0] TILE_COLORS = {
    3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 3'b111,
    3'b111, 3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001
  };

endpackage

// File: rtl/board_renderer_if.sv
// Shadow-board write port: cell writes with a valid/ready handshake plus a
// one-cycle commit pulse that publishes the shadow board at the next blanking.
interface board_renderer_if;
  import board_pkg::*;

  logic wr_valid;
  logic wr_ready;
  logic [3:0] wr_idx;
  exp_t wr_exp;
  logic wr_commit;

  modport master (output wr_valid, output wr_idx, output wr_exp, output wr_commit,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_idx, input  wr_exp, input  wr_commit,
                  output wr_ready);

endinterface

// File: rtl/tile_color_lut.sv
// Combinational exponent-to-colour map; the blink bit only affects exponent 11.
module tile_color_lut
  import board_pkg::*;
(
  input  exp_t   tile_exp,
  input  logic   blink,
  output color_t color
);

  // Look up the tile colour, overriding exponent 11 while blinking.
  always_comb begin
    color = COL_BG;
    if (blink && (tile_exp == EXP_BLINK)) begin
      color = COL_BLINK;
    end else begin
      color = TILE_COLORS[tile_exp];
    end
  end

endmodule

// File: rtl/board_renderer.sv
// Renders a double-buffered 4x4 tile board into the VGA pixel stream with a
// fixed 2-cycle latency. Optional macro TILE_BLINK_EN makes exponent 11 blink.
module board_renderer
  import board_pkg::*;
#(
  parameter int BOARD_X0  = 192,
  parameter int BOARD_Y0  = 112,
  parameter int CELL_LOG2 = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] col,
  input  logic [9:0] row,
  input  logic       vnotactive,
  output logic       rin,
  output logic       gin,
  output logic       bin,
  board_renderer_if.slave wr
);

  localparam logic [10:0] X_LO      = 11'(BOARD_X0);
  localparam logic [10:0] X_HI      = 11'(BOARD_X0 + (4 << CELL_LOG2));
  localparam logic [10:0] Y_LO      = 11'(BOARD_Y0);
  localparam logic [10:0] Y_HI      = 11'(BOARD_Y0 + (4 << CELL_LOG2));
  localparam logic [10:0] CELL_MASK = 11'((1 << CELL_LOG2) - 1);

  board_t     shadow_r;
  board_t     display_r;
  logic       pending_r;
  logic       vna_d_r;
  logic       s1_in_r;
  logic       s1_border_r;
  logic       s1_vna_r;
  logic [3:0] s1_idx_r;
  color_t     rgb_r;

  logic        edge_s;
  logic        copy_s;
  logic        wr_fire_s;
  logic        blink_s;
  logic [10:0] dx_s;
  logic [10:0] dy_s;
  logic [1:0]  cx_s;
  logic [1:0]  cy_s;
  logic        in_board_s;
  logic        border_s;
  color_t      lut_color_s;

  assign edge_s    = vnotactive & ~vna_d_r;
  assign copy_s    = edge_s & (pending_r | wr.wr_commit);
  assign wr_fire_s = wr.wr_valid & ~pending_r;
  assign wr.wr_ready = ~pending_r;

  // Unsigned 11-bit offsets: columns left of the board wrap high and fail the range test.
  assign dx_s = {1'b0, col} - X_LO;
  assign dy_s = {1'b0, row} - Y_LO;
  assign cx_s = 2'(dx_s >> CELL_LOG2);
  assign cy_s = 2'(dy_s >> CELL_LOG2);
  assign in_board_s = ({1'b0, col} >= X_LO) && ({1'b0, col} < X_HI) &&
                      ({1'b0, row} >= Y_LO) && ({1'b0, row} < Y_HI);
  assign border_s   = ((dx_s & CELL_MASK) < 11'(BORDER_PX)) ||
                      ((dy_s & CELL_MASK) < 11'(BORDER_PX));

  // Shadow writes, commit tracking and the blanking-time publish to the display board.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_r  <= '0;
      display_r <= '0;
      pending_r <= 1'b0;
      vna_d_r   <= 1'b0;
    end else begin
      vna_d_r <= vnotactive;
      if (copy_s) begin
        display_r <= shadow_r;
        pending_r <= 1'b0;
      end else if (wr.wr_commit) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (wr_fire_s) begin
        shadow_r[wr.wr_idx] <= wr.wr_exp;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

`ifdef TILE_BLINK_EN
  logic [4:0] frame_cnt_r;

  // Frame counter drives the blink phase: 16 frames steady, 16 frames bright.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt_r <= 5'd0;
    end else if (edge_s) begin
      frame_cnt_r <= frame_cnt_r + 5'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign blink_s = frame_cnt_r[4];
`else
  assign blink_s = 1'b0;
`endif

  tile_color_lut u_lut (
    .tile_exp (display_r[s1_idx_r]),
    .blink    (blink_s),
    .color    (lut_color_s)
  );

  // Stage 1 geometry decode, stage 2 colour select.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_in_r     <= 1'b0;
      s1_border_r <= 1'b0;
      s1_vna_r    <= 1'b0;
      s1_idx_r    <= 4'd0;
      rgb_r       <= COL_BG;
    end else begin
      s1_in_r     <= in_board_s;
      s1_border_r <= border_s;
      s1_vna_r    <= vnotactive;
      s1_idx_r    <= {cy_s, cx_s};
      if (s1_vna_r || !s1_in_r) begin
        rgb_r <= COL_BG;
      end else if (s1_border_r) begin
        rgb_r <= COL_BORDER;
      end else begin
        rgb_r <= lut_color_s;
      end
    end
  end

  assign rin = rgb_r[2];
  assign gin = rgb_r[1];
  assign bin = rgb_r[0];

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: expected pixels are queued at drive
// time from a behavioural board model and compared two cycles later.
module tb_board_renderer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] col;
  logic [9:0] row;
  logic       vnotactive;
  logic       rin;
  logic       gin;
  logic       bin;

  board_renderer_if wr_bus ();

  board_renderer dut (
    .CLK        (CLK),
    .RST        (RST),
    .col        (col),
    .row        (row),
    .vnotactive (vnotactive),
    .rin        (rin),
    .gin        (gin),
    .bin        (bin),
    .wr         (wr_bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         chk;
    logic [2:0] rgb;
    int         id;
  } pix_exp_t;

  pix_exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pix_id   = 0;

  logic [3:0] shad_m [16];
  logic [3:0] disp_m [16];
  bit         pend_m;
  bit         vprev_m;
  int         frame_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic bit blink_m();
`ifdef TILE_BLINK_EN
    return ((frame_m % 32) >= 16);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] lut_m(input logic [3:0] e, input bit blink);
    case (e)
      4'd0:    return 3'b001;
      4'd1:    return 3'b010;
      4'd2:    return 3'b011;
      4'd3:    return 3'b100;
      4'd4:    return 3'b101;
      4'd5:    return 3'b110;
      4'd11:   return blink ? 3'b111 : 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [2:0] pix_m(input int c, input int r, input bit v);
    int dx = c - 192;
    int dy = r - 112;
    if (v) return 3'b000;
    if (dx < 0 || dx >= 256 || dy < 0 || dy >= 256) return 3'b000;
    if ((dx % 64) < 2 || (dy % 64) < 2) return 3'b111;
    return lut_m(disp_m[(dy / 64) * 4 + dx / 64], blink_m());
  endfunction

  // One clock: drive inputs, queue the expected pixel, advance the model, score.
  task automatic tick(input int c, input int r, input bit v, input bit valid,
                      input int idx, input int e, input bit commit, input bit chk);
    pix_exp_t pe;
    bit edge_m;
    col = 10'(c);
    row = 10'(r);
    vnotactive = v;
    wr_bus.wr_valid  = valid;
    wr_bus.wr_idx    = 4'(idx);
    wr_bus.wr_exp    = 4'(e);
    wr_bus.wr_commit = commit;
    exp_q.push_back('{chk, pix_m(c, r, v), pix_id});
    pix_id++;
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        shad_m[i] = 4'd0;
        disp_m[i] = 4'd0;
      end
      pend_m = 1'b0; vprev_m = 1'b0; frame_m = 0;
    end else begin
      edge_m = v && !vprev_m;
      if (edge_m && (pend_m || commit)) begin
        for (int i = 0; i < 16; i++) disp_m[i] = shad_m[i];
      end
      if (valid && !pend_m) shad_m[idx] = 4'(e);
      if (edge_m && (pend_m || commit)) pend_m = 1'b0;
      else if (commit) pend_m = 1'b1;
      if (edge_m) frame_m++;
      vprev_m = v;
    end
    @(posedge CLK);
    #1;
    if (RST) begin
      exp_q.delete();
    end else if (exp_q.size() == 2) begin
      pe = exp_q.pop_front();
      if (pe.chk) check($sformatf("pix%0d", pe.id), 32'({rin, gin, bin}), 32'(pe.rgb));
    end
  endtask

  task automatic px(input int c, input int r, input bit chk);
    tick(c, r, 1'b0, 1'b0, 0, 0, 1'b0, chk);
  endtask

  task automatic wr_cell(input int idx, input int e, input bit commit);
    tick(300, 200, 1'b0, 1'b1, idx, e, commit, 1'b0);
  endtask

  task automatic frame();
    tick(0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick(0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic scan_all();
    for (int i = 0; i < 16; i++) px(192 + (i % 4) * 64 + 32, 112 + (i / 4) * 64 + 32, 1'b1);
    px(0, 0, 1'b0);
    px(0, 0, 1'b0);
  endtask

  task automatic check_ready(input string tag);
    check(tag, 32'(wr_bus.wr_ready), 32'(!pend_m));
  endtask

  initial begin
    RST = 1'b1;
    // Reset with an in-board pixel that would otherwise render as an empty tile.
    for (int i = 0; i < 3; i++) tick(300, 200, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    check("rst_rgb", 32'({rin, gin, bin}), 32'd0);
    check_ready("rst_ready");
    RST = 1'b0;
    scan_all();

    // Geometry boundaries.
    px(191, 150, 1'b1); px(192, 112, 1'b1); px(194, 114, 1'b1); px(448, 150, 1'b1);
    px(300, 111, 1'b1); px(300, 368, 1'b1); px(447, 367, 1'b1); px(193, 200, 1'b1);
    px(0, 0, 1'b0); px(0, 0, 1'b0);

    // Write, commit in active video, stalled write, publish at blanking.
    wr_cell(5, 1, 1'b0);
    wr_cell(0, 0, 1'b1);
    check_ready("pend_ready");
    wr_cell(0, 3, 1'b0);
    check_ready("pend_stall");
    px(260, 180, 1'b1); px(0, 0, 1'b0); px(0, 0, 1'b0);
    tick(0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    check_ready("post_edge_ready");
    tick(0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    px(260, 180, 1'b1); px(224, 144, 1'b1); px(0, 0, 1'b0); px(0, 0, 1'b0);

    // Commit coinciding with the blanking edge.
    wr_cell(6, 2, 1'b0);
    tick(0, 0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    check_ready("coinc_ready");
    tick(0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    px(352, 208, 1'b1); px(0, 0, 1'b0); px(0, 0, 1'b0);

    // Reset while a commit is pending.
    wr_cell(9, 4, 1'b1);
    check_ready("rstpend_ready");
    RST = 1'b1;
    tick(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    RST = 1'b0;
    check_ready("rstpend_clear");
    frame();
    scan_all();

    // Full LUT: cell i holds exponent i.
    for (int i = 0; i < 16; i++) wr_cell(i, i, 1'b0);
    wr_cell(0, 0, 1'b1);
    frame();
    scan_all();

    // Blink phase of exponent 11 across more than one counter period.
    for (int f = 0; f < 40; f++) begin
      frame();
      px(192 + 3 * 64 + 32, 112 + 2 * 64 + 32, 1'b1);
    end
    px(0, 0, 1'b0); px(0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
